// File: rtl/divided_clock_meter_if.sv
// divided_clock_meter_if: enable/signal inputs and measurement results of the divided clock meter
interface divided_clock_meter_if #(parameter int W = 16);
  logic en;
  logic sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic valid;
  logic ovf;
  logic locked;
  modport master(output en, sig_in, input period, high_time, valid, ovf, locked);
  modport slave(input en, sig_in, output period, high_time, valid, ovf, locked);
endinterface

// File: rtl/divided_clock_meter.sv
// divided_clock_meter: measures period and high time of a clk-synchronous strobe, rise to rise
module divided_clock_meter #(parameter int W = 16) (
  input logic clk,
  input logic rst,
  divided_clock_meter_if.slave m
);
  typedef enum logic {IDLE, MEAS} state_t;
  state_t state_q, state_d;
  logic sig_d_q;
  logic [W-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d, period_q, period_d, high_q, high_d;
  logic valid_q, valid_d, ovf_q, ovf_d;
  logic rise, sat, meas, start, close, inc;
  assign rise = m.sig_in & ~sig_d_q;
  assign sat = &per_cnt_q;
  assign meas = state_q == MEAS;
  assign start = m.en & rise;
  assign close = meas & start;
  assign inc = meas & m.en & ~rise & ~sat;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_d_q <= 1'b1;
      per_cnt_q <= '0;
      hi_cnt_q <= '0;
      period_q <= '0;
      high_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_d_q <= m.sig_in;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q <= hi_cnt_d;
      period_q <= period_d;
      high_q <= high_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
    end
  end
  // disable beats a coincident rise; saturation only ends a measurement when no rise closes it
  always_comb begin
    state_d = state_q;
    if (!meas) state_d = start ? MEAS : IDLE;
    else state_d = !m.en ? IDLE : rise ? MEAS : sat ? IDLE : MEAS;
  end
  always_comb begin
    per_cnt_d = start ? W'(1) : inc ? per_cnt_q + W'(1) : per_cnt_q;
    hi_cnt_d = start ? W'(1) : inc ? hi_cnt_q + W'(m.sig_in) : hi_cnt_q;
    period_d = close ? per_cnt_q : period_q;
    high_d = close ? hi_cnt_q : high_q;
    valid_d = close;
    ovf_d = meas & m.en & ~rise & sat;
  end
  assign m.period = period_q;
  assign m.high_time = high_q;
  assign m.valid = valid_q;
  assign m.ovf = ovf_q;
  assign m.locked = meas;
endmodule

// File: tb/tb_divided_clock_meter.sv
// tb_divided_clock_meter: directed checks of a W=16 and a W=4 meter sharing clk/rst
module tb_divided_clock_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  divided_clock_meter_if #(16) a();
  divided_clock_meter_if #(4) b();
  divided_clock_meter #(.W(16)) u16 (.clk(clk), .rst(rst), .m(a));
  divided_clock_meter #(.W(4)) u4 (.clk(clk), .rst(rst), .m(b));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic s);
    a.sig_in = s;
    tick();
  endtask
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0d exp=%0d", t, got, exp);
    end
  endtask
  task automatic res(input logic s);
    rst = 1'b1;
    a.sig_in = s;
    b.sig_in = 1'b0;
    tick();
    rst = 1'b0;
  endtask
  task automatic chk_meas(input string t, input logic v, input int p, input int h);
    chk({t, "_valid"}, a.valid, v);
    chk({t, "_period"}, a.period, p);
    chk({t, "_high"}, a.high_time, h);
  endtask
  initial begin
    a.en = 1'b1;
    b.en = 1'b1;
    res(1'b0);
    chk("rst_period", a.period, 0);
    chk("rst_high", a.high_time, 0);
    chk("rst_valid", a.valid, 0);
    chk("rst_ovf", a.ovf, 0);
    chk("rst_locked", a.locked, 0);
    // T1: 1,1,0 pattern; a leading 0 is needed since reset leaves sig_d high
    put(0);
    put(1);
    chk("t1_lock", a.locked, 1);
    chk("t1_novalid", a.valid, 0);
    put(1); put(0); put(1);
    chk_meas("t1_first", 1, 3, 2);
    put(1);
    chk("t1_pulse", a.valid, 0);
    put(0); put(1);
    chk_meas("t1_second", 1, 3, 2);
    // T2: 1,0,0,0,0 pattern
    res(1'b0);
    put(0); put(1);
    chk("t2_lock", a.locked, 1);
    for (int k = 0; k < 2; k++) begin
      put(0); put(0); put(0); put(0);
      chk("t2_wait", a.valid, 0);
      put(1);
      chk_meas("t2_meas", 1, 5, 1);
      chk("t2_locked", a.locked, 1);
    end
    // T3: W=4, single rise then constant 0; ovf on the 15th counted cycle
    res(1'b0);
    b.sig_in = 1'b0; tick();
    b.sig_in = 1'b1; tick();
    chk("t3_lock", b.locked, 1);
    b.sig_in = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("t3_ovf", b.ovf, i == 15);
      chk("t3_locked", b.locked, i < 15);
      chk("t3_valid", b.valid, 0);
    end
    chk("t3_period", b.period, 0);
    chk("t3_high", b.high_time, 0);
    // T4: en dropped on a rise
    res(1'b0);
    put(0); put(1); put(1); put(0);
    a.en = 1'b0;
    put(1);
    chk("t4_valid", a.valid, 0);
    chk("t4_locked", a.locked, 0);
    chk("t4_period", a.period, 0);
    a.en = 1'b1;
    put(1); put(0);
    chk("t4_idle", a.locked, 0);
    put(1);
    chk("t4_rearm", a.locked, 1);
    chk("t4_rearm_valid", a.valid, 0);
    put(1); put(0); put(1);
    chk_meas("t4_meas", 1, 3, 2);
    // T5: high through reset release, then toggling
    res(1'b1);
    for (int i = 0; i < 10; i++) put(1);
    chk("t5_nolock", a.locked, 0);
    chk("t5_novalid", a.valid, 0);
    put(0); put(1);
    chk("t5_lock", a.locked, 1);
    chk("t5_pre", a.valid, 0);
    put(0); put(1);
    chk_meas("t5_meas", 1, 2, 1);
    // T6: reset mid-measurement after several valids
    put(0); put(1);
    chk_meas("t6_before", 1, 2, 1);
    put(0);
    rst = 1'b1;
    put(1);
    rst = 1'b0;
    chk_meas("t6_rst", 0, 0, 0);
    chk("t6_locked", a.locked, 0);
    chk("t6_ovf", a.ovf, 0);
    put(0); put(1);
    chk("t6_relock", a.locked, 1);
    put(0); put(1);
    chk_meas("t6_meas", 1, 2, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
